// File: rtl/hazard_unit.sv
// Pipeline hazard control for the five-stage MIPS core: forwarding selects,
// stall/flush generation and a busy tracker for the multi-cycle mult/div unit.
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       pcsrcD,
    input  logic       jumpD,
    input  logic       mdstartE,
    input  logic       mdopE,
    input  logic       mdstartD,
    input  logic       hiloreadD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mdbusy,
    output logic       mddone
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    // The counter holds the number of busy cycles still to come after this one.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    logic [1:0] fwd_e [2];
    logic       fwd_d [2];

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall_any;

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;
    assign src_d[0] = rsD;
    assign src_d[1] = rtD;

    // Operand A and B share the same rules; Memory beats Writeback.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_e[gi] = (src_e[gi] != 5'd0 && regwriteM && writeregM == src_e[gi]) ? 2'b10 :
                               (src_e[gi] != 5'd0 && regwriteW && writeregW == src_e[gi]) ? 2'b01 :
                                                                                            2'b00;
            assign fwd_d[gi] = (src_d[gi] != 5'd0) && regwriteM && (writeregM == src_d[gi]);
        end
    endgenerate

    assign forwardAE = fwd_e[0];
    assign forwardBE = fwd_e[1];
    assign forwardAD = fwd_d[0];
    assign forwardBD = fwd_d[1];

    assign lwstall = memtoregE && (rtE != 5'd0) && (rtE == rsD || rtE == rtD);

    assign branchstall = branchD &&
        ((regwriteE && writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD)) ||
         (memtoregM && writeregM != 5'd0 && (writeregM == rsD || writeregM == rtD)));

    // The mddone cycle does not stall: HI/LO are written at its closing edge.
    assign mdstall = (hiloreadD || mdstartD) &&
                     ((state_reg == BUSY && count_reg != '0) || mdstartE);

    assign stall_any = lwstall || branchstall || mdstall;
    assign stallF    = stall_any;
    assign stallD    = stall_any;
    assign flushE    = stall_any;
    assign flushD    = (pcsrcD || jumpD) && !stall_any;

    assign mdbusy = (state_reg == BUSY);
    assign mddone = (state_reg == BUSY) && (count_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (mdstartE) begin
                    state_next = BUSY;
                    count_next = mdopE ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (count_reg != '0) begin
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// cycles compared against a remaining-busy-cycles reference model.
module tb_hazard_unit;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD, pcsrcD, jumpD;
    logic       mdstartE, mdopE, mdstartD, hiloreadD;
    logic       stallF, stallD, flushD, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       mdbusy, mddone;

    int checks   = 0;
    int failures = 0;
    int rem      = 0;  // model: busy cycles still ahead, including the current one

    hazard_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rsD      (rsD),
        .rtD      (rtD),
        .rsE      (rsE),
        .rtE      (rtE),
        .writeregE(writeregE),
        .writeregM(writeregM),
        .writeregW(writeregW),
        .regwriteE(regwriteE),
        .regwriteM(regwriteM),
        .regwriteW(regwriteW),
        .memtoregE(memtoregE),
        .memtoregM(memtoregM),
        .branchD  (branchD),
        .pcsrcD   (pcsrcD),
        .jumpD    (jumpD),
        .mdstartE (mdstartE),
        .mdopE    (mdopE),
        .mdstartD (mdstartD),
        .hiloreadD(hiloreadD),
        .stallF   (stallF),
        .stallD   (stallD),
        .flushD   (flushD),
        .flushE   (flushE),
        .forwardAD(forwardAD),
        .forwardBD(forwardBD),
        .forwardAE(forwardAE),
        .forwardBE(forwardBE),
        .mdbusy   (mdbusy),
        .mddone   (mddone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; pcsrcD = 0; jumpD = 0;
        mdstartE = 0; mdopE = 0; mdstartD = 0; hiloreadD = 0;
    endtask

    // Reference rules, written from the hazard definitions.
    function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (regwriteM && writeregM == src) return 2'd2;
        if (regwriteW && writeregW == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic ref_fwd_d(input logic [4:0] src);
        return (src != 0) && regwriteM && (writeregM == src);
    endfunction

    function automatic logic reads(input logic [4:0] r);
        return (r != 0) && (r == rsD || r == rtD);
    endfunction

    function automatic logic ref_stall();
        logic lw, br, md;
        lw = memtoregE && reads(rtE);
        br = branchD && ((regwriteE && reads(writeregE)) || (memtoregM && reads(writeregM)));
        md = (hiloreadD || mdstartD) && (rem > 1 || mdstartE);
        return lw || br || md;
    endfunction

    task automatic check_all(input string tag);
        logic s;
        s = ref_stall();
        check({tag, ".stallF"},    32'(stallF),    32'(s));
        check({tag, ".stallD"},    32'(stallD),    32'(s));
        check({tag, ".flushE"},    32'(flushE),    32'(s));
        check({tag, ".flushD"},    32'(flushD),    32'((pcsrcD || jumpD) && !s));
        check({tag, ".forwardAE"}, 32'(forwardAE), 32'(ref_fwd_e(rsE)));
        check({tag, ".forwardBE"}, 32'(forwardBE), 32'(ref_fwd_e(rtE)));
        check({tag, ".forwardAD"}, 32'(forwardAD), 32'(ref_fwd_d(rsD)));
        check({tag, ".forwardBD"}, 32'(forwardBD), 32'(ref_fwd_d(rtD)));
        check({tag, ".mdbusy"},    32'(mdbusy),    32'(rem > 0));
        check({tag, ".mddone"},    32'(mddone),    32'(rem == 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt, done_cnt, done_at;

        // Reset state
        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset.mdbusy", 32'(mdbusy), 32'd0);
        check("reset.mddone", 32'(mddone), 32'd0);
        check("reset.stallD", 32'(stallD), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset: mdbusy=%0b mddone=%0b", mdbusy, mddone);

        // Load-use, including the register-zero exclusion
        @(negedge clk); clear_inputs();
        memtoregE = 1; rtE = 8; rsD = 8; #1;
        check("lw.stallF", 32'(stallF), 32'd1);
        check("lw.stallD", 32'(stallD), 32'd1);
        check("lw.flushE", 32'(flushE), 32'd1);
        $display("txn load-use r8: stallD=%0b flushE=%0b", stallD, flushE);
        rtE = 0; rsD = 0; #1;
        check("lw0.stallF", 32'(stallF), 32'd0);
        check("lw0.stallD", 32'(stallD), 32'd0);
        check("lw0.flushE", 32'(flushE), 32'd0);
        $display("txn load-use r0: stallD=%0b flushE=%0b", stallD, flushE);

        // Execute forwarding priority
        @(negedge clk); clear_inputs();
        rsE = 9; regwriteM = 1; writeregM = 9; regwriteW = 1; writeregW = 9; #1;
        check("fwdAE.M", 32'(forwardAE), 32'd2);
        regwriteM = 0; #1;
        check("fwdAE.W", 32'(forwardAE), 32'd1);
        rsE = 0; #1;
        check("fwdAE.zero", 32'(forwardAE), 32'd0);
        rtE = 9; #1;
        check("fwdBE.W", 32'(forwardBE), 32'd1);
        $display("txn forward priority: AE=%0d BE=%0d", forwardAE, forwardBE);

        // Branch on a load: stalls with the load in E, then in M
        @(negedge clk); clear_inputs();
        branchD = 1; rsD = 4; memtoregE = 1; writeregE = 4; rtE = 4; regwriteE = 1; #1;
        check("brlw.E.stallD", 32'(stallD), 32'd1);
        @(negedge clk);
        memtoregE = 0; regwriteE = 0; writeregE = 0; rtE = 0;
        memtoregM = 1; regwriteM = 1; writeregM = 4; #1;
        check("brlw.M.stallD", 32'(stallD), 32'd1);
        check("brlw.M.forwardAD", 32'(forwardAD), 32'd1);
        @(negedge clk);
        memtoregM = 0; regwriteM = 0; writeregM = 0;
        regwriteW = 1; writeregW = 4; #1;
        check("brlw.W.stallD", 32'(stallD), 32'd0);
        $display("txn branch-on-load: released stallD=%0b", stallD);

        // Branch on an ALU result: one stall, then forward from M
        @(negedge clk); clear_inputs();
        branchD = 1; rtD = 6; regwriteE = 1; writeregE = 6; #1;
        check("bralu.E.stallD", 32'(stallD), 32'd1);
        @(negedge clk);
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 6; #1;
        check("bralu.M.stallD", 32'(stallD), 32'd0);
        check("bralu.M.forwardBD", 32'(forwardBD), 32'd1);
        $display("txn branch-on-alu: forwardBD=%0b", forwardBD);

        // Multiply with a HI/LO reader held in Decode
        @(negedge clk); clear_inputs();
        mdstartE = 1; mdopE = 0; hiloreadD = 1; #1;
        check("mul.start.stallD", 32'(stallD), 32'd1);
        check("mul.start.mdbusy", 32'(mdbusy), 32'd0);
        for (int k = 1; k <= MULT_N; k++) begin
            @(negedge clk); mdstartE = 0; #1;
            check($sformatf("mul.c%0d.mdbusy", k), 32'(mdbusy), 32'd1);
            check($sformatf("mul.c%0d.mddone", k), 32'(mddone), 32'(k == MULT_N));
            check($sformatf("mul.c%0d.stallD", k), 32'(stallD), 32'(k < MULT_N));
        end
        @(negedge clk); #1;
        check("mul.end.mdbusy", 32'(mdbusy), 32'd0);
        check("mul.end.stallD", 32'(stallD), 32'd0);
        $display("txn multiply: mdbusy=%0b stallD=%0b after completion", mdbusy, stallD);

        // Divide aborted by an asynchronous reset
        @(negedge clk); clear_inputs();
        mdstartE = 1; mdopE = 1;
        @(negedge clk); mdstartE = 0;
        repeat (9) @(negedge clk);
        #1;
        check("divrst.pre.mdbusy", 32'(mdbusy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("divrst.async.mdbusy", 32'(mdbusy), 32'd0);
        check("divrst.async.mddone", 32'(mddone), 32'd0);
        @(posedge clk); #1;
        check("divrst.held.mdbusy", 32'(mdbusy), 32'd0);
        check("divrst.held.mddone", 32'(mddone), 32'd0);
        @(negedge clk); reset = 1'b0;
        $display("txn divide-reset: mdbusy=%0b mddone=%0b", mdbusy, mddone);

        // Full divide after reset release
        @(negedge clk); mdstartE = 1; mdopE = 1;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= DIV_N + 2; k++) begin
            @(negedge clk); mdstartE = 0; #1;
            if (mdbusy) busy_cnt++;
            if (mddone) begin done_cnt++; done_at = k; end
        end
        check("div.busy_cycles", 32'(busy_cnt), 32'(DIV_N));
        check("div.done_pulses", 32'(done_cnt), 32'd1);
        check("div.done_cycle",  32'(done_at),  32'(DIV_N));
        $display("txn divide: busy=%0d done_at=%0d", busy_cnt, done_at);

        // Taken branch, alone and against a load-use stall
        @(negedge clk); clear_inputs();
        pcsrcD = 1; #1;
        check("taken.flushD", 32'(flushD), 32'd1);
        check("taken.stallD", 32'(stallD), 32'd0);
        memtoregE = 1; rtE = 5; rsD = 5; #1;
        check("taken_lw.flushD", 32'(flushD), 32'd0);
        check("taken_lw.stallD", 32'(stallD), 32'd1);
        $display("txn taken-branch: flushD=%0b with stall", flushD);

        // Random cycles against the reference model
        @(negedge clk); clear_inputs(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        rem = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom % 2); regwriteM = 1'($urandom % 2);
            regwriteW = 1'($urandom % 2);
            memtoregE = ($urandom % 3) == 0; memtoregM = ($urandom % 3) == 0;
            branchD = 1'($urandom % 2); pcsrcD = ($urandom % 3) == 0;
            jumpD = ($urandom % 5) == 0;
            mdstartE = (rem == 0) ? (($urandom % 6) == 0) : (($urandom % 25) == 0);
            mdopE = 1'($urandom % 2);
            mdstartD = ($urandom % 3) == 0; hiloreadD = ($urandom % 3) == 0;
            #1;
            check_all($sformatf("rnd%0d", i));
            $display("txn rnd%0d: stall=%0b flushD=%0b fAE=%0d fBE=%0d busy=%0b done=%0b",
                     i, stallD, flushD, forwardAE, forwardBE, mdbusy, mddone);
            @(posedge clk);
            if (rem > 0) rem--;
            else if (mdstartE) rem = mdopE ? DIV_N : MULT_N;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage MIPS core. It generates the stall (enable) and flush (clear) controls consumed by the enable/clear pipeline registers, plus the forwarding selects for the Decode and Execute stages. It also tracks a multi-cycle multiply/divide unit with a small state machine, so that HI/LO readers and back-to-back mult/div ops stall until the result is committed.

## Interface
- MULT_CYCLES, 4, busy cycles for a multiply (>=1)
- DIV_CYCLES, 32, busy cycles for a divide (>=1)
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- rsD, rtD  in  5 each  source registers of instruction in Decode
- rsE, rtE  in  5 each  source registers of instruction in Execute
- writeregE, writeregM, writeregW  in  5 each  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1 each  stage writes register file
- memtoregE, memtoregM  in  1 each  stage instruction is a load
- branchD  in  1  Decode holds a branch (compare in Decode)
- pcsrcD  in  1  branch taken, resolved in Decode
- jumpD  in  1  Decode holds a jump
- mdstartE  in  1  Execute holds mult/div this cycle
- mdopE  in  1  0 = multiply, 1 = divide
- mdstartD  in  1  Decode holds mult/div
- hiloreadD  in  1  Decode holds mfhi/mflo
- stallF, stallD  out  1  hold Fetch/Decode registers (register enable = ~stall)
- flushD, flushE  out  1  clear Decode/Execute registers
- forwardAD, forwardBD  out  1  forward ALUOutM to Decode comparator operand A/B
- forwardAE, forwardBE  out  2  Execute operand select: 00 regfile, 01 ResultW, 10 ALUOutM
- mdbusy  out  1  mult/div unit busy (registered state)
- mddone  out  1  last busy cycle; HI/LO written at the closing edge

## Operation
- Forwarding (combinational):
  - forwardAE = 10 if rsE!=0 && regwriteM && writeregM==rsE.
  - Otherwise forwardAE = 01 if rsE!=0 && regwriteW && writeregW==rsE.
  - Otherwise forwardAE = 00.
  - forwardBE is the same with rtE. M has priority over W.
  - forwardAD = rsD!=0 && regwriteM && writeregM==rsD; forwardBD likewise with rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD). Register zero is excluded: no stall when the matching register is 0.
- branchstall = branchD && ((regwriteE && writeregE!=0 && writeregE∈{rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM∈{rsD,rtD})).
- mdstall = (hiloreadD || mdstartD) && ((state==BUSY && count!=0) || mdstartE).
- stallF = stallD = lwstall | branchstall | mdstall.
- flushE = stallD. The Execute stage receives a bubble.
- flushD = (pcsrcD | jumpD) & ~stallD.
- FSM states are IDLE and BUSY.
  - IDLE: if mdstartE, load count = (mdopE ? DIV_CYCLES : MULT_CYCLES) - 1 and go to BUSY.
  - BUSY: if count!=0, decrement. If count==0, go to IDLE.
  - mdstartE while in BUSY is ignored. It cannot legally occur, because Decode is stalled.
- mdbusy = (state==BUSY). mddone = (state==BUSY && count==0).

## Timing
- Reset:
  - state = IDLE, count = 0, mdbusy = 0, mddone = 0.
  - The combinational outputs follow the inputs, with the FSM state taken as IDLE.
  - Reset asserted mid-operation aborts the op immediately and asynchronously. mdbusy drops without a clock edge, and mddone is never pulsed.
- mdstartE sampled at edge t → mdbusy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). mddone is high in the N-th cycle only.
- A HI/LO reader or mult/div in Decode stalls in the mdstartE cycle and in every BUSY cycle except the mddone cycle. It advances to Execute at the edge that ends the mddone cycle.
- With N=1: BUSY lasts one cycle, with mddone high in that cycle. A dependent instruction in Decode stalls only during the mdstartE cycle.
- Load-use stalls last 1 cycle. A branch depending on ALU in E stalls 1 cycle. A branch depending on a load in E stalls 2 cycles (E, then M).
- If a stall coincides with pcsrcD/jumpD, the stall wins: flushD=0 that cycle, and the flush applies once the stall clears.

## Test plan
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1. Repeat with rtE=0, rsD=0 → all 0.
- Forward priority: rsE=9, regwriteM=1, writeregM=9, regwriteW=1, writeregW=9 → forwardAE=10. Drop regwriteM → 01. Set rsE=0 → 00.
- Branch dependency: branchD=1, rsD=4, memtoregE=1, writeregE=4, regwriteE=1 → stall for 2 cycles. Advancing to M sets memtoregM=1, writeregM=4, and forwardAD=1 in the cycle after.
- Multiply: mdstartE=1, mdopE=0, hiloreadD=1 held → stallD high for 4 cycles (start cycle + 3 BUSY with count!=0). mdbusy is high 4 cycles and mddone pulses in the 4th.
- Divide with reset: mdstartE=1, mdopE=1, reset asserted 10 cycles later → mdbusy=0 immediately, no mddone. After release, mdstartE with mdopE=1 gives mdbusy for 32 cycles.
- Taken branch: pcsrcD=1 with no hazards → flushD=1, stallD=0. With lwstall active → flushD=0.
